button_conditioner: RTL
=======================

// Module: button_conditioner
// PURPOSE
//   Multi-channel push-button conditioner: synchronises N raw button inputs, debounces
//   each one against a slow sampling tick, and emits level, press, release and
//   auto-repeat strobes in the clk domain. Sits between the board buttons and the game
//   FSM / maze controller, and replaces the single-channel, single-sample reset-button
//   debouncer.
// PARAMETERS
//   N_BTN         5   number of independent button channels
//   SYNC_STAGES   2   flops in each raw-input synchroniser chain (>=2)
//   STABLE_TICKS  3   consecutive tick samples that must disagree with level before it flips (>=1)
//   ACTIVE_LOW    0   1: raw input is 0 when pressed (inverted after synchroniser)
//   REPEAT_DELAY  50  ticks of continuous hold before the first repeat strobe (>=1)
//   REPEAT_RATE   10  ticks between later repeat strobes (>=1)
// PORTS
//   clk          in   1      system clock
//   rst_n        in   1      asynchronous active-low reset
//   tick_in      in   1      slow sampling clock (~100 Hz, 50% duty), synchronous to clk
//   btn_raw      in   N_BTN  raw button pins
//   btn_level    out  N_BTN  debounced state, 1 = pressed
//   btn_press    out  N_BTN  1-clk strobe on each debounced 0->1 transition
//   btn_release  out  N_BTN  1-clk strobe on each debounced 1->0 transition
//   btn_repeat   out  N_BTN  1-clk auto-repeat strobe while a button is held
// BEHAVIOUR
//   Reset: all outputs, synchroniser flops, counters and tick history are 0; every FSM is IDLE.
//   Tick: two-flop history of tick_in; tick_pulse = cur & ~prev, exactly 1 clk per rising edge.
//     The history resets to 0, so if tick_in is high when reset releases, one pulse fires.
//   Sync: each btn_raw bit passes through SYNC_STAGES flops, then is XORed with ACTIVE_LOW -> s.
//   Debounce (per channel, evaluated only on tick_pulse):
//     s == level -> cnt := 0.
//     s != level and cnt == STABLE_TICKS-1 -> level := ~level, cnt := 0.
//     Otherwise -> cnt := cnt + 1.
//     With STABLE_TICKS=1 the block degenerates to single-sample debouncing.
//     Any one agreeing sample discards all progress (glitch rejection).
//   Strobes are registered. press/release are high on the clk after level changes.
//   Latency from a stable raw edge to the strobe: SYNC_STAGES clk
//     + STABLE_TICKS tick_pulses + 1 clk.
//   Repeat FSM (per channel): IDLE -> DELAY on press, rcnt := 0.
//     DELAY: on each tick_pulse rcnt++. When rcnt reaches REPEAT_DELAY: strobe repeat,
//       rcnt := 0, go to REPEAT.
//     REPEAT: on each tick_pulse rcnt++. When rcnt reaches REPEAT_RATE: strobe repeat, rcnt := 0.
//     Release in any state -> IDLE the same cycle, rcnt := 0, and no repeat strobe that cycle.
//     press and repeat never assert in the same cycle.
//   Boundaries:
//     tick_in stuck -> no level changes and no repeats.
//     Channels are fully independent; simultaneous presses give simultaneous strobes.
//     Reset mid-bounce or mid-hold: level returns to 0. A still-held button must re-qualify
//       through STABLE_TICKS samples and then produce a fresh press.
//     Counters are sized with $clog2(max+1) and never wrap.
// STRUCTURE
//   Package button_pkg: repeat FSM state encodings (IDLE/DELAY/REPEAT) and the width
//     helper localparams.
//   Sub-module debounce_channel: synchroniser, debounce counter, repeat FSM and
//     strobes for one bit. It is instantiated N_BTN times in a generate loop.
//   The top level holds only the shared tick edge detector and the port fan-out.
// TESTING
//   Clean press: btn_raw[0] 0->1 held, STABLE_TICKS=3 -> btn_press[0] high for 1 clk
//     after the 3rd tick_pulse (+SYNC_STAGES+1 clk); btn_level[0]=1.
//   Bounce: toggle btn_raw[1] 1,0,1,1,1 on successive ticks -> single press after the
//     3rd consecutive 1, no earlier strobe.
//   Hold: hold btn_raw[2] for 100 ticks -> repeat strobes at ticks 50, 60, 70, 80, 90
//     and 100 after the press; release -> 1 release strobe, no further repeats.
//   Short hold: release at tick 30 -> press and release only, zero repeat strobes.
//   Reset mid-hold: assert rst_n=0 with btn_raw[3] held -> all outputs 0 at once; after
//     release, press reappears 3 ticks later.
//   ACTIVE_LOW=1, N_BTN=5: drive all raw bits 0 simultaneously -> all 5 press bits assert
//     in the same cycle.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and sizing helpers for the push-button conditioner.
package button_pkg;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    localparam int unsigned DEF_N_BTN        = 5;
    localparam int unsigned DEF_SYNC_STAGES  = 2;
    localparam int unsigned DEF_STABLE_TICKS = 3;
    localparam int unsigned DEF_REPEAT_DELAY = 50;
    localparam int unsigned DEF_REPEAT_RATE  = 10;

    // Bits needed to hold 0..max_val; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        if (max_val == 0) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchroniser, tick-sampled debounce counter, strobes and auto-repeat FSM.
module debounce_channel
    import button_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
    parameter bit          ACTIVE_LOW   = 1'b0,
    parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_pulse,
    input  logic raw,
    output logic level,
    output logic press,
    output logic lift,
    output logic rpt
);

    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned CNT_W   = cnt_width(STABLE_TICKS);
    localparam int unsigned RCNT_W  = cnt_width(RPT_MAX);

    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(STABLE_TICKS - 1);
    localparam logic [RCNT_W-1:0] DELAY_LAST = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] RATE_LAST  = RCNT_W'(REPEAT_RATE - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   flip, rise, fall;
    rpt_state_t             state_q, state_d;
    logic [RCNT_W-1:0]      rcnt_q, rcnt_d;
    logic                   press_q, lift_q, rpt_q, rpt_d;

    assign s    = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;
    assign rise = flip & ~level_q;
    assign fall = flip & level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            state_q <= RPT_IDLE;
            rcnt_q  <= '0;
            press_q <= 1'b0;
            lift_q  <= 1'b0;
            rpt_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            press_q <= rise;
            lift_q  <= fall;
            rpt_q   <= rpt_d;
        end
    end

    // A single agreeing sample clears all accumulated disagreement.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        flip    = 1'b0;
        if (tick_pulse) begin
            if (s == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
                cnt_d   = '0;
                flip    = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Release wins over any repeat due in the same cycle.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        rpt_d   = 1'b0;
        if (fall) begin
            state_d = RPT_IDLE;
            rcnt_d  = '0;
        end else begin
            case (state_q)
                RPT_IDLE: begin
                    if (rise) begin
                        state_d = RPT_DELAY;
                        rcnt_d  = '0;
                    end
                end
                RPT_DELAY: begin
                    if (tick_pulse) begin
                        if (rcnt_q == DELAY_LAST) begin
                            rpt_d   = 1'b1;
                            rcnt_d  = '0;
                            state_d = RPT_REPEAT;
                        end else begin
                            rcnt_d = rcnt_q + RCNT_W'(1);
                        end
                    end
                end
                RPT_REPEAT: begin
                    if (tick_pulse) begin
                        if (rcnt_q == RATE_LAST) begin
                            rpt_d  = 1'b1;
                            rcnt_d = '0;
                        end else begin
                            rcnt_d = rcnt_q + RCNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = RPT_IDLE;
                    rcnt_d  = '0;
                end
            endcase
        end
    end

    assign level = level_q;
    assign press = press_q;
    assign lift  = lift_q;
    assign rpt   = rpt_q;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: shared sampling-tick edge detector feeding N debounce channels.
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned N_BTN        = DEF_N_BTN,
    parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
    parameter bit          ACTIVE_LOW   = 1'b0,
    parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_in,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);

    logic [1:0] tick_q;
    logic       tick_pulse;

    // History resets low, so a tick already high at reset release yields one pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= '0;
        end else begin
            tick_q <= {tick_q[0], tick_in};
        end
    end

    assign tick_pulse = tick_q[0] & ~tick_q[1];

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_TICKS (STABLE_TICKS),
            .ACTIVE_LOW   (ACTIVE_LOW),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .tick_pulse (tick_pulse),
            .raw        (btn_raw[i]),
            .level      (btn_level[i]),
            .press      (btn_press[i]),
            .lift       (btn_release[i]),
            .rpt        (btn_repeat[i])
        );
    end

endmodule
